// File: rtl/signalled_sender_pkg.sv
// ---------------------------------------------------------------------------
// signalled_sender_pkg
//   Shared router types: the AXI-Stream beat structs carried between the
//   crossbar, the egress sender and the downstream signalled queue, and the
//   sender FSM state encoding.
// ---------------------------------------------------------------------------
package signalled_sender_pkg;

    localparam int AXIS_DATA_WIDTH = 40;
    localparam int ID_WIDTH        = 4;
    localparam int DEST_WIDTH      = 4;
    localparam int USER_WIDTH      = 4;

    typedef logic [AXIS_DATA_WIDTH-1:0] axis_data_t;

    // Forward-going beat: valid plus payload sidebands.
    typedef struct packed {
        logic                  TVALID;
        axis_data_t            TDATA;
        logic                  TLAST;
        logic [ID_WIDTH-1:0]   TID;
        logic [DEST_WIDTH-1:0] TDEST;
        logic [USER_WIDTH-1:0] TUSER;
    } axis_mosi_t;

    // Backward-going flow control.
    typedef struct packed {
        logic TREADY;
    } axis_miso_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        THROTTLE = 2'd2,
        STALL    = 2'd3
    } sender_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
//   Two-entry AXI-Stream FIFO with a registered TREADY. The consumer pops the
//   head explicitly, so the same buffer can feed any issue policy.
//
//   clk_i     in   clock
//   rst_n_i   in   asynchronous active-low reset
//   s_mosi_i  in   incoming beats
//   s_miso_o  out  registered TREADY (high while fewer than two entries held)
//   pop_i     in   consume the head this cycle (only while head_o.TVALID)
//   head_o    out  oldest entry; TVALID flags a non-empty buffer
// ---------------------------------------------------------------------------
module axis_skid_buffer
    import signalled_sender_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  axis_mosi_t s_mosi_i,
    output axis_miso_t s_miso_o,
    input  logic       pop_i,
    output axis_mosi_t head_o
);

    axis_mosi_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;
    logic [1:0] occ_next;
    logic       push;

    assign push = s_mosi_i.TVALID && s_miso_o.TREADY;

    // Simultaneous push and pop leave occupancy, and so TREADY, unchanged.
    always_comb begin
        occ_next = occ;
        case ({push, pop_i})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            occ             <= 2'd0;
            s_miso_o.TREADY <= 1'b1;
        end else begin
            if (push)  wr_ptr <= ~wr_ptr;
            if (pop_i) rd_ptr <= ~rd_ptr;
            occ             <= occ_next;
            s_miso_o.TREADY <= (occ_next < 2'd2);
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= s_mosi_i;
    end

    always_comb begin
        head_o        = mem[rd_ptr];
        head_o.TVALID = (occ != 2'd0);
    end

endmodule

// File: rtl/signalled_sender.sv
// ---------------------------------------------------------------------------
// signalled_sender
//   Egress transmitter feeding a downstream signalled queue. Beats from the
//   local crossbar pass through a two-entry skid buffer into a registered
//   output stage; issue into that stage is paced by the remote queue status
//   (full stalls, half-full throttles, otherwise free-running).
//
//   clk_i               in   clock
//   rst_n_i             in   asynchronous active-low reset
//   in_mosi_i           in   beats from the crossbar
//   in_miso_o           out  registered TREADY toward the crossbar
//   out_mosi_o          out  registered link beat toward the remote queue
//   out_miso_i          in   TREADY from the remote queue
//   remote_empty_i      in   remote queue empty
//   remote_half_full_i  in   remote queue more than half full
//   remote_full_i       in   remote queue full
//   sent_count_o        out  completed output handshakes (wrapping)
//   stall_cycles_o      out  STALL cycles with a beat held (saturating)
// ---------------------------------------------------------------------------
module signalled_sender
    import signalled_sender_pkg::*;
#(
    parameter int THROTTLE_GAP = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  axis_mosi_t           in_mosi_i,
    output axis_miso_t           in_miso_o,
    output axis_mosi_t           out_mosi_o,
    input  axis_miso_t           out_miso_i,
    input  logic                 remote_empty_i,
    input  logic                 remote_half_full_i,
    input  logic                 remote_full_i,
    output logic [CNT_WIDTH-1:0] sent_count_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o
);

    localparam int               GAP_W      = $clog2(THROTTLE_GAP) + 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(THROTTLE_GAP - 1);

    axis_mosi_t       head;
    logic             load;
    logic             in_fire;
    logic             out_fire;
    logic             pending;
    logic             issue_ok;
    sender_state_e    state;
    sender_state_e    state_next;
    logic [GAP_W-1:0] gap_cnt;

    axis_skid_buffer u_skid (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .s_mosi_i (in_mosi_i),
        .s_miso_o (in_miso_o),
        .pop_i    (load),
        .head_o   (head)
    );

    assign in_fire  = in_mosi_i.TVALID && in_miso_o.TREADY;
    assign out_fire = out_mosi_o.TVALID && out_miso_i.TREADY;
    assign pending  = head.TVALID || out_mosi_o.TVALID || in_fire;

    // Status priority: full over half-full over empty/none.
    always_comb begin
        casez ({remote_full_i, remote_half_full_i, remote_empty_i})
            3'b1??:  state_next = STALL;
            3'b01?:  state_next = THROTTLE;
            default: state_next = pending ? SEND : IDLE;
        endcase
    end

    // The output stage adds one cycle between load and handshake, so while
    // throttled the next beat is loaded when gap_cnt reaches 1 (ready to
    // complete as the gap expires), or at 0 if the stage is already empty.
    // Loading at 0 while a beat is still presented would pair handshakes.
    always_comb begin
        issue_ok = 1'b0;
        case (state)
            IDLE, SEND: issue_ok = 1'b1;
            THROTTLE:   issue_ok = (THROTTLE_GAP == 1) ||
                                   (gap_cnt == GAP_W'(1)) ||
                                   ((gap_cnt == '0) && !out_mosi_o.TVALID);
            default:    issue_ok = 1'b0;
        endcase
    end

    assign load = (!out_mosi_o.TVALID || out_fire) && head.TVALID && issue_ok;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A presented beat stays until its handshake, whatever the status does.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_mosi_o <= '0;
        end else if (load) begin
            out_mosi_o <= head;
        end else if (out_fire) begin
            out_mosi_o.TVALID <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gap_cnt <= '0;
        end else if (state_next == SEND || state_next == IDLE) begin
            gap_cnt <= '0;
        end else if (state == THROTTLE && out_fire) begin
            gap_cnt <= GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sent_count_o   <= '0;
            stall_cycles_o <= '0;
        end else begin
            if (out_fire) sent_count_o <= sent_count_o + 1'b1;
            if (state == STALL && (head.TVALID || out_mosi_o.TVALID) &&
                stall_cycles_o != '1)
                stall_cycles_o <= stall_cycles_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_signalled_sender.sv
module tb_signalled_sender;
    import signalled_sender_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    axis_mosi_t  in_mosi;
    axis_miso_t  in_miso;
    axis_mosi_t  out_mosi;
    axis_miso_t  out_miso;
    logic        remote_empty;
    logic        remote_half;
    logic        remote_full;
    logic [15:0] sent_count;
    logic [15:0] stall_cycles;

    always #5 clk_i = ~clk_i;

    signalled_sender #(.THROTTLE_GAP(4), .CNT_WIDTH(16)) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .in_mosi_i          (in_mosi),
        .in_miso_o          (in_miso),
        .out_mosi_o         (out_mosi),
        .out_miso_i         (out_miso),
        .remote_empty_i     (remote_empty),
        .remote_half_full_i (remote_half),
        .remote_full_i      (remote_full),
        .sent_count_o       (sent_count),
        .stall_cycles_o     (stall_cycles)
    );

    int                         n_checks = 0;
    int                         n_errs   = 0;
    int                         cyc      = 0;
    logic [AXIS_DATA_WIDTH-1:0] src      = 40'd1;
    logic [AXIS_DATA_WIDTH-1:0] exp_q [$];
    int                         hs_at [longint];
    logic [15:0]                sent_model  = '0;
    logic [15:0]                stall_model = '0;
    logic                       full_last   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of traffic: account for the handshakes about to happen at
    // the next edge, then check the post-edge outputs against the model.
    task automatic tick();
        logic                       in_f, out_f, hold, was_stall, prev_v;
        logic [AXIS_DATA_WIDTH-1:0] held_d;
        in_mosi.TDATA = src;
        in_mosi.TID   = src[3:0];
        in_mosi.TDEST = src[7:4];
        in_mosi.TUSER = src[11:8];
        in_mosi.TLAST = src[0];
        in_f      = in_mosi.TVALID && in_miso.TREADY;
        out_f     = out_mosi.TVALID && out_miso.TREADY;
        was_stall = full_last;
        if (full_last && exp_q.size() != 0 && stall_model != 16'hFFFF)
            stall_model++;
        hold   = out_mosi.TVALID && !out_miso.TREADY;
        held_d = out_mosi.TDATA;
        prev_v = out_mosi.TVALID;
        if (out_f) begin
            if (exp_q.size() == 0) begin
                chk("stray_beat_queue", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("order", out_mosi.TDATA, exp_q.pop_front());
                hs_at[longint'(out_mosi.TDATA)] = cyc + 1;
                sent_model++;
            end
        end
        if (in_f) begin
            exp_q.push_back(src);
            src++;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        full_last = remote_full;
        chk("sent_count", sent_count, sent_model);
        chk("stall_cycles", stall_cycles, stall_model);
        chk("in_ready", in_miso.TREADY, (exp_q.size() - int'(out_mosi.TVALID)) < 2);
        if (hold) begin
            chk("hold_valid", out_mosi.TVALID, 1'b1);
            chk("hold_data", out_mosi.TDATA, held_d);
        end
        if (was_stall)
            chk("stall_noload", out_mosi.TVALID && (!prev_v || out_f), 1'b0);
    endtask

    task automatic settle(input int n);
        in_mosi.TVALID  = 1'b0;
        out_miso.TREADY = 1'b1;
        remote_full     = 1'b0;
        remote_half     = 1'b0;
        remote_empty    = 1'b0;
        repeat (n) tick();
    endtask

    // Offer beats until src passes last; bounded so a dead DUT cannot hang us.
    task automatic push_until(input logic [AXIS_DATA_WIDTH-1:0] last, input string tag);
        int guard;
        guard = 0;
        in_mosi.TVALID = 1'b1;
        while (src <= last && guard < 200) begin
            tick();
            guard++;
        end
        in_mosi.TVALID = 1'b0;
        if (guard >= 200) chk(tag, 64'(src), 64'(last + 1));
    endtask

    initial begin
        int nfull;
        int guard;
        logic [15:0] st0;
        in_mosi         = '0;
        out_miso.TREADY = 1'b0;
        remote_full     = 1'b0;
        remote_half     = 1'b0;
        remote_empty    = 1'b0;
        rst_n_i         = 1'b1;
        #2 rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_out_valid", out_mosi.TVALID, 1'b0);
        chk("rst_out_data", out_mosi.TDATA, '0);
        chk("rst_in_ready", in_miso.TREADY, 1'b1);
        chk("rst_sent", sent_count, '0);
        chk("rst_stall", stall_cycles, '0);
        rst_n_i = 1'b1;

        // Basic forwarding, beats 1..8.
        out_miso.TREADY = 1'b1;
        in_mosi.TVALID  = 1'b1;
        tick();
        chk("lat_not_early", out_mosi.TVALID, 1'b0);
        tick();
        chk("lat_valid", out_mosi.TVALID, 1'b1);
        chk("lat_data", out_mosi.TDATA, 40'd1);
        push_until(40'd8, "basic_timeout");
        settle(5);
        chk("basic_sent", sent_count, 16'd8);
        chk("basic_rate", 64'(hs_at[8] - hs_at[1]), 64'd7);

        // Full stall: beat 9 presented and held, 10 and 11 in the skid.
        out_miso.TREADY = 1'b0;
        push_until(40'd9, "stall_push9");
        tick();
        chk("stall_presented", out_mosi.TVALID, 1'b1);
        remote_full    = 1'b1;
        in_mosi.TVALID = 1'b1;
        for (nfull = 0; nfull < 10; nfull++) begin
            if (src > 40'd11) in_mosi.TVALID = 1'b0;
            tick();
        end
        in_mosi.TVALID = 1'b0;
        chk("stall_in_ready", in_miso.TREADY, 1'b0);
        chk("stall_held_data", out_mosi.TDATA, 40'd9);
        chk("stall_sent", sent_count, 16'd8);
        remote_full     = 1'b0;
        out_miso.TREADY = 1'b1;
        push_until(40'd14, "resume_timeout");
        settle(6);
        chk("stall_total", stall_cycles, 16'd10);
        for (int i = 10; i < 14; i++)
            chk("resume_rate", 64'(hs_at[i+1] - hs_at[i]), 64'd1);

        // Throttle: beats 15..20, gap 4, then release.
        remote_half     = 1'b1;
        out_miso.TREADY = 1'b1;
        in_mosi.TVALID  = 1'b1;
        guard = 0;
        while (!hs_at.exists(18) && guard < 200) begin
            if (src > 40'd20) in_mosi.TVALID = 1'b0;
            tick();
            guard++;
        end
        if (guard >= 200) chk("thr_timeout", 64'(guard), 64'd0);
        remote_half = 1'b0;
        push_until(40'd20, "thr_push");
        settle(8);
        for (int i = 15; i < 18; i++)
            chk("thr_gap", 64'(hs_at[i+1] - hs_at[i]), 64'd4);
        chk("thr_release", 64'(hs_at[20] - hs_at[19]), 64'd1);

        // Backpressure: TREADY pattern 1,0,0,1 while streaming 21..32.
        in_mosi.TVALID = 1'b1;
        guard = 0;
        while ((src <= 40'd32 || exp_q.size() != 0) && guard < 300) begin
            if (src > 40'd32) in_mosi.TVALID = 1'b0;
            out_miso.TREADY = (guard % 4 == 0) || (guard % 4 == 3);
            tick();
            guard++;
        end
        settle(3);
        chk("bp_sent", sent_count, 16'd32);

        // Priority: full, half-full and empty together behave as STALL.
        st0 = stall_cycles;
        remote_full  = 1'b1;
        remote_half  = 1'b1;
        remote_empty = 1'b1;
        in_mosi.TVALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (src > 40'd34) in_mosi.TVALID = 1'b0;
            tick();
        end
        chk("prio_no_issue", out_mosi.TVALID, 1'b0);
        chk("prio_in_ready", in_miso.TREADY, 1'b0);
        chk("prio_stall", 64'(stall_cycles - st0), 64'd5);
        settle(6);
        chk("prio_sent", sent_count, 16'd34);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 1500; i++) begin
            in_mosi.TVALID  = ($urandom_range(0, 3) != 0);
            out_miso.TREADY = ($urandom_range(0, 2) != 0);
            remote_full     = ($urandom_range(0, 7) == 0);
            remote_half     = ($urandom_range(0, 4) == 0);
            remote_empty    = $urandom_range(0, 1) == 1;
            tick();
        end
        settle(12);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream with two beats held.
        out_miso.TREADY = 1'b0;
        push_until(src + 1, "rst_fill");
        tick();
        chk("rst_pre_held", 64'(exp_q.size()), 64'd2);
        #3 rst_n_i = 1'b0;
        #1;
        chk("arst_out_valid", out_mosi.TVALID, 1'b0);
        chk("arst_in_ready", in_miso.TREADY, 1'b1);
        chk("arst_sent", sent_count, '0);
        chk("arst_stall", stall_cycles, '0);
        in_mosi.TVALID = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        exp_q.delete();
        sent_model  = '0;
        stall_model = '0;
        full_last   = 1'b0;
        rst_n_i     = 1'b1;
        settle(4);
        chk("post_rst_idle", out_mosi.TVALID, 1'b0);
        push_until(src + 2, "post_rst_push");
        settle(5);
        chk("post_rst_sent", sent_count, 16'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
